// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the PC sequencer.
//   state_e        - sequencer state encoding (BOOT=0, RUN=1, HALT=2, FAULT=3)
//   XLEN_DEF       - default PC / branch-target width
//   HALT_INSTR_DEF - default instruction word that ends execution
//   PC_INC         - sequential PC increment in bytes
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int          XLEN_DEF       = 32;
  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_006F;
  localparam int          PC_INC         = 4;
endpackage

// File: rtl/pc_seq_counter.sv
// pc_seq_counter: up counter with synchronous clear and count enable.
//   SAT=1 : counting stops at MAX
//   SAT=0 : counter wraps modulo 2^W (MAX unused)
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_clr          - synchronous clear (wins over i_en)
//   i_en           - count enable
//   o_count        - current count
module pc_seq_counter #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255,
  parameter bit          SAT = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = SAT && (r_cnt == MAX_V);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_en && !w_at_max) r_cnt <= r_cnt + W'(1);
  end

  assign o_count = r_cnt;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with BOOT/RUN/HALT/FAULT control.
// Optional feature macro: PC_SEQUENCER_TIMEOUT_EN -- when defined, RUN ends in
// HALT (timed_out=1) once cycle_count reaches MAX_CYCLES.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   stall               - hold PC this cycle (cycle budget still advances)
//   restart             - pulse, leaves HALT/FAULT back to BOOT
//   instr, instr_valid  - instruction at pc_out, used for halt detection
//   branch_taken/target - redirect request; misaligned target faults
//   pc_out, next_pc     - registered PC and the value it takes at next edge
//   pc_write            - PC loads a new value at next edge
//   state, halted       - current state, state==HALT
//   timed_out           - sticky, HALT entered by budget exhaustion
//   cycle_count         - saturating RUN-cycle count
//   retired             - wrapping count of PC updates in RUN
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [31:0]     HALT_INSTR = HALT_INSTR_DEF,
  parameter int              MAX_CYCLES = 80,
  localparam int             CW         = $clog2(MAX_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            restart,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write,
  output logic [1:0]      state,
  output logic            halted,
  output logic            timed_out,
  output logic [CW-1:0]   cycle_count,
  output logic [31:0]     retired
);
  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_armed;     // first edge after reset release seen
  logic            r_timed_out;
  logic            w_pcw, w_ret_en, w_cyc_en, w_clr, w_to_set;
  logic            w_is_halt, w_misalign, w_budget;

  assign w_is_halt  = instr_valid && (instr == HALT_INSTR);
  assign w_misalign = branch_target[1:0] != 2'b00;

`ifdef PC_SEQUENCER_TIMEOUT_EN
  // Fires in the RUN cycle whose edge brings cycle_count to MAX_CYCLES.
  assign w_budget = (r_state == ST_RUN) && (cycle_count == CW'(MAX_CYCLES - 1));
`else
  assign w_budget = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pcw       = 1'b0;
    w_ret_en    = 1'b0;
    w_cyc_en    = 1'b0;
    w_clr       = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      // BOOT spans the cycle that starts at the reset-release edge.
      ST_BOOT: if (r_armed) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_cyc_en = 1'b1;
        if (!stall && w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_budget) begin
          w_state_nxt = ST_HALT;
          w_to_set    = 1'b1;
        end else if (stall) begin
          w_state_nxt = ST_RUN;
        end else if (branch_taken && w_misalign) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_pcw    = 1'b1;
          w_ret_en = 1'b1;
          w_pc_nxt = branch_taken ? branch_target : r_pc + XLEN'(PC_INC);
        end
      end
      ST_HALT, ST_FAULT: begin
        if (restart) begin
          w_state_nxt = ST_BOOT;
          w_pc_nxt    = RESET_VEC;
          w_pcw       = 1'b1;
          w_clr       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VEC;
      r_armed     <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_armed <= 1'b1;
      if (w_clr)         r_timed_out <= 1'b0;
      else if (w_to_set) r_timed_out <= 1'b1;
    end
  end

  pc_seq_counter #(.W(CW), .MAX(MAX_CYCLES), .SAT(1'b1)) u_cycle_cnt (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_clr), .i_en(w_cyc_en), .o_count(cycle_count)
  );

  pc_seq_counter #(.W(32), .MAX(0), .SAT(1'b0)) u_retired_cnt (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_clr), .i_en(w_ret_en), .o_count(retired)
  );

  assign pc_out    = r_pc;
  assign next_pc   = w_pc_nxt;
  assign pc_write  = w_pcw;
  assign state     = r_state;
  assign halted    = (r_state == ST_HALT);
  assign timed_out = r_timed_out;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] HLT = 32'h0000_006F;
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        reset, stall, restart, instr_valid, branch_taken;
  logic [31:0] instr, branch_target;
  logic [31:0] pc_out, next_pc, retired;
  logic        pc_write, halted, timed_out;
  logic [1:0]  state;
  logic [6:0]  cycle_count;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .restart(restart),
    .instr(instr), .instr_valid(instr_valid), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .next_pc(next_pc),
    .pc_write(pc_write), .state(state), .halted(halted), .timed_out(timed_out),
    .cycle_count(cycle_count), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [31:0] pc, npc, cc, ret;
    logic        pcw, to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drv(input logic s, input logic rs, input logic [31:0] ins,
                     input logic iv, input logic bt, input logic [31:0] tgt);
    stall = s; restart = rs; instr = ins; instr_valid = iv;
    branch_taken = bt; branch_target = tgt;
  endtask

  // Expected view of the DUT after the stimulus just driven settles.
  task automatic chk(input string nm, input logic [1:0] st, input logic [31:0] pc,
                     input logic [31:0] npc, input logic pcw, input logic [31:0] cc,
                     input logic [31:0] ret, input logic to);
    exp_t e;
    e.name = nm; e.st = st; e.pc = pc; e.npc = npc; e.pcw = pcw;
    e.cc = cc; e.ret = ret; e.to = to;
    q.push_back(e);
  endtask

  // Monitor: compares once per cycle, after inputs driven on negedge settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({state, pc_out, next_pc, pc_write, 32'(cycle_count), retired, timed_out, halted} !==
            {e.st, e.pc, e.npc, e.pcw, e.cc, e.ret, e.to, (e.st == S_HALT)}) begin
          errors++;
          $display("FAIL %s: got st=%0d pc=%h npc=%h pcw=%b cc=%0d ret=%0d to=%b hlt=%b want st=%0d pc=%h npc=%h pcw=%b cc=%0d ret=%0d to=%b hlt=%b",
                   e.name, state, pc_out, next_pc, pc_write, cycle_count, retired, timed_out, halted,
                   e.st, e.pc, e.npc, e.pcw, e.cc, e.ret, e.to, (e.st == S_HALT));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; drv(0, 0, NOP, 1, 0, 0);
    chk("rst", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    chk("rel", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("boot", S_BOOT, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef PC_SEQUENCER_TIMEOUT_EN
  // Run a NOP stream from RUN entry until the budget (80) expires.
  task automatic budget_run(input logic halt_last);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 79 && halt_last) drv(0, 0, HLT, 1, 0, 0);
      if (k == 79) chk("tmo_edge", S_RUN, 32'(4*k), 32'(4*k), 0, 32'(k), 32'(k), 0);
      else         chk("tmo_run", S_RUN, 32'(4*k), 32'(4*k+4), 1, 32'(k), 32'(k), 0);
    end
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0);
    chk("tmo_halt", S_HALT, 316, 316, 0, 80, 79, !halt_last);
    @(negedge clk); drv(0, 1, NOP, 1, 0, 0);
    chk("tmo_rst", S_HALT, 316, 0, 1, 80, 79, !halt_last);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0);
    chk("tmo_boot", S_BOOT, 0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drv(0, 0, NOP, 1, 0, 0);
    @(negedge clk); chk("rst0", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1; chk("rel0", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("boot0", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("run0", S_RUN, 0, 4, 1, 0, 0, 0);
    @(negedge clk); chk("seq4", S_RUN, 4, 8, 1, 1, 1, 0);
    @(negedge clk); drv(1, 0, NOP, 1, 0, 0); chk("stall1", S_RUN, 8, 8, 0, 2, 2, 0);
    @(negedge clk); chk("stall2", S_RUN, 8, 8, 0, 3, 2, 0);
    @(negedge clk); chk("stall3", S_RUN, 8, 8, 0, 4, 2, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0); chk("unstall", S_RUN, 8, 32'hC, 1, 5, 2, 0);
    @(negedge clk); chk("seqC", S_RUN, 32'hC, 32'h10, 1, 6, 3, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 1, 32'h40); chk("br40", S_RUN, 32'h10, 32'h40, 1, 7, 4, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 1, 32'h1C); chk("br1C", S_RUN, 32'h40, 32'h1C, 1, 8, 5, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0); chk("seq1C", S_RUN, 32'h1C, 32'h20, 1, 9, 6, 0);
    // halt instruction beats a misaligned branch in the same cycle
    @(negedge clk); drv(0, 0, HLT, 1, 1, 32'h42); chk("hlt_pri", S_RUN, 32'h20, 32'h20, 0, 10, 7, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0); chk("halt", S_HALT, 32'h20, 32'h20, 0, 11, 7, 0);
    @(negedge clk); chk("halt_hold", S_HALT, 32'h20, 32'h20, 0, 11, 7, 0);
    @(negedge clk); drv(0, 1, NOP, 1, 0, 0); chk("restart", S_HALT, 32'h20, 0, 1, 11, 7, 0);
    @(negedge clk); chk("boot_rs", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rs_run", S_RUN, 0, 4, 1, 0, 0, 0);
    @(negedge clk); drv(0, 0, HLT, 0, 0, 0); chk("hlt_inv", S_RUN, 4, 8, 1, 1, 1, 0);
    @(negedge clk); drv(1, 0, HLT, 1, 1, 32'h42); chk("stall_ign", S_RUN, 8, 8, 0, 2, 2, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0); chk("run8", S_RUN, 8, 32'hC, 1, 3, 2, 0);
    @(negedge clk); chk("runC", S_RUN, 32'hC, 32'h10, 1, 4, 3, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 1, 32'h42); chk("flt_req", S_RUN, 32'h10, 32'h10, 0, 5, 4, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0); chk("fault", S_FAULT, 32'h10, 32'h10, 0, 6, 4, 0);
    @(negedge clk); drv(0, 1, NOP, 1, 0, 0); chk("flt_rst", S_FAULT, 32'h10, 0, 1, 6, 4, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 1, 32'h40); chk("boot3", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("br40b", S_RUN, 0, 32'h40, 1, 0, 0, 0);
    // reset asserted between edges while a branch to 0x80 is requested
    @(negedge clk); drv(0, 0, NOP, 1, 1, 32'h80); reset = 1'b0;
    chk("async_rst", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1; drv(0, 0, NOP, 1, 1, 32'hFFFF_FFF8);
    chk("rel2", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("boot4", S_BOOT, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("brFF8", S_RUN, 0, 32'hFFFF_FFF8, 1, 0, 0, 0);
    @(negedge clk); drv(0, 0, NOP, 1, 0, 0);
    chk("seqFFC", S_RUN, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 1, 1, 0);
    @(negedge clk); chk("wrap", S_RUN, 32'hFFFF_FFFC, 0, 1, 2, 2, 0);
    @(negedge clk); chk("wrap0", S_RUN, 0, 4, 1, 3, 3, 0);

    do_reset();
`ifdef PC_SEQUENCER_TIMEOUT_EN
    budget_run(1'b0);
    budget_run(1'b1);
`else
    // no timeout: cycle_count saturates at 80 while the PC keeps running
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      chk("sat", S_RUN, 32'(4*k), 32'(4*k+4), 1, (k > 80) ? 32'd80 : 32'(k), 32'(k), 0);
    end
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32: PC and branch-target width.
REQ-002 Parameter RESET_VEC, default 32'h00000000: PC value loaded in BOOT.
REQ-003 Parameter HALT_INSTR, default 32'h0000006F: instruction word that ends execution.
REQ-004 Parameter MAX_CYCLES, default 80: RUN-cycle budget before timeout; CW = $clog2(MAX_CYCLES+1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  hold PC this cycle.
REQ-008 restart  input  1  one-cycle pulse; leaves HALT/FAULT.
REQ-009 instr  input  32  instruction at pc_out.
REQ-010 instr_valid  input  1  instr is valid this cycle.
REQ-011 branch_taken  input  1  redirect request from EX.
REQ-012 branch_target  input  XLEN  redirect address.
REQ-013 pc_out  output  XLEN  current PC (registered).
REQ-014 next_pc  output  XLEN  combinational PC to be loaded at next edge.
REQ-015 pc_write  output  1  high when PC updates at next edge.
REQ-016 state  output  2  BOOT=0, RUN=1, HALT=2, FAULT=3.
REQ-017 halted  output  1  state==HALT.
REQ-018 timed_out  output  1  sticky: HALT entered via budget exhaustion.
REQ-019 cycle_count  output  CW  RUN cycles elapsed, saturating.
REQ-020 retired  output  32  count of PC updates in RUN, wraps modulo 2^32.

Function
REQ-021 BOOT lasts exactly one cycle, pc_write=0, then unconditional transition to RUN.
REQ-022 In RUN with stall=1: pc_out, retired hold; pc_write=0; halt/branch/fault ignored; cycle_count still increments.
REQ-023 In RUN with stall=0, priority: halt > fault > branch > sequential.
REQ-024 Halt: instr_valid=1 and instr==HALT_INSTR -> HALT next cycle, pc_out held, pc_write=0, timed_out=0.
REQ-025 Fault: branch_taken=1 and branch_target[1:0]!=0 -> FAULT next cycle, pc_out held.
REQ-026 Branch: branch_taken=1 with aligned target -> pc_out=branch_target after one edge, retired+1.
REQ-027 Sequential: pc_out=pc_out+4 after one edge, modulo 2^XLEN (0xFFFFFFFC -> 0x00000000), retired+1.
REQ-028 next_pc equals the value pc_out will take at the next edge in every state.
REQ-029 HALT and FAULT hold all counters and pc_out; restart=1 -> BOOT next cycle, pc_out=RESET_VEC, cycle_count=0, retired=0, timed_out=0.
REQ-030 restart is ignored in BOOT and RUN.
REQ-031 instr_valid=0 suppresses halt detection only.

Reset
REQ-032 reset=0 asynchronously forces state=BOOT, pc_out=RESET_VEC, cycle_count=0, retired=0, timed_out=0, regardless of state or pending branch.
REQ-033 Release is sampled on a rising clk edge; BOOT begins from that edge.

Configuration
REQ-034 Macro PC_SEQUENCER_TIMEOUT_EN defined: when cycle_count reaches MAX_CYCLES in RUN, transition to HALT with timed_out=1; halt instruction in the same cycle wins (timed_out=0).
REQ-035 Macro undefined: no timeout; cycle_count saturates at MAX_CYCLES; timed_out tied 0.

Structure
REQ-036 Shared package holds the state encoding enum, XLEN default, HALT_INSTR default, and PC increment constant 4.
REQ-037 One sub-module, pc_seq_counter: parametrised saturating/wrapping counter with clear and enable, instanced for cycle_count and retired.

Verification
REQ-038 Reset release, instr=NOP, no stall -> BOOT 1 cycle, then pc_out 0,4,8,C on successive edges; retired=3 after the third update.
REQ-039 At pc_out=0x10 assert branch_taken with target 0x40 -> pc_out=0x40 next edge; target 0x42 -> state=FAULT, pc_out=0x10 held.
REQ-040 At pc_out=0x20 drive instr=0x0000006F, instr_valid=1 -> state=HALT, halted=1, pc_out=0x20 held; restart pulse -> BOOT, pc_out=0.
REQ-041 stall=1 for 3 cycles at pc_out=0x8 -> pc_out stays 0x8, pc_write=0, cycle_count +3, retired unchanged.
REQ-042 TIMEOUT_EN, MAX_CYCLES=80, NOP stream -> after 80 RUN cycles state=HALT, timed_out=1; halt instr on cycle 80 -> timed_out=0.
REQ-043 Assert reset=0 mid-branch at pc_out=0x40 -> immediately pc_out=RESET_VEC, state=BOOT, counters 0.
